// File: rtl/timer_control.sv
// Upstream control for the countdown/stopwatch digit counters: button
// synchronisation and debounce, the IDLE/SET/RUN mode machine that drives
// the shared state bus, and the four-digit preset register.
module timer_control #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter logic [15:0] DIGIT_MAX       = 16'h5959
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_reset,
  input  logic        btn_set,
  input  logic        btn_start,
  input  logic        btn_inc,
  input  logic        btn_sel,
  output logic [3:0]  state,
  output logic [15:0] set_bits,
  output logic [1:0]  sel_digit,
  output logic        editing
);

  localparam int NB    = 5;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button bit positions inside the conditioned vectors.
  localparam int B_RST   = 0;
  localparam int B_SET   = 1;
  localparam int B_START = 2;
  localparam int B_INC   = 3;
  localparam int B_SEL   = 4;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SET  = 4'd1,
    S_RUN  = 4'd3
  } mode_t;

  logic [NB-1:0]    w_raw;
  logic [NB-1:0]    r_sync1, r_sync2;
  logic [NB-1:0]    r_db, r_db_d, r_pulse;
  logic [CNT_W-1:0] r_cnt [NB];

  mode_t       r_mode, w_mode_nxt;
  logic [15:0] r_set_bits, w_set_bits_nxt;
  logic [1:0]  r_sel, w_sel_nxt;
  logic [3:0]  w_digit, w_dmax, w_digit_inc;

  assign w_raw = {btn_sel, btn_inc, btn_start, btn_set, btn_reset};

  // Two-flop synchroniser for the raw, clock-asynchronous buttons.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
      r_db <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_db[i]  <= ~r_db[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // One-cycle press pulse on each rising edge of the debounced level; releases are silent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_db_d  <= '0;
      r_pulse <= '0;
    end else begin
      r_db_d  <= r_db;
      r_pulse <= r_db & ~r_db_d;
    end
  end

  // Mode, preset and digit-select registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= S_IDLE;
      r_set_bits <= '0;
      r_sel      <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_set_bits <= w_set_bits_nxt;
      r_sel      <= w_sel_nxt;
    end
  end

  assign w_digit     = r_set_bits[{r_sel, 2'b00} +: 4];
  assign w_dmax      = DIGIT_MAX[{r_sel, 2'b00} +: 4];
  assign w_digit_inc = (w_digit == w_dmax) ? 4'd0 : w_digit + 4'd1;

  // Next-state and edit logic; only the highest-priority pulse acts (reset > start > set > sel > inc).
  always_comb begin
    w_mode_nxt     = r_mode;
    w_set_bits_nxt = r_set_bits;
    w_sel_nxt      = r_sel;
    if (r_pulse[B_RST]) begin
      w_mode_nxt = S_IDLE;
    end else if (r_pulse[B_START]) begin
      w_mode_nxt = S_RUN;
    end else if (r_pulse[B_SET]) begin
      case (r_mode)
        S_IDLE: begin
          w_mode_nxt = S_SET;
          w_sel_nxt  = 2'd0;
        end
        S_SET:   w_mode_nxt = S_IDLE;
        default: w_mode_nxt = r_mode;
      endcase
    end else if (r_pulse[B_SEL]) begin
      if (r_mode == S_SET) w_sel_nxt = r_sel + 2'd1;
    end else if (r_pulse[B_INC]) begin
      if (r_mode == S_SET) w_set_bits_nxt[{r_sel, 2'b00} +: 4] = w_digit_inc;
    end
  end

  assign state     = r_mode;
  assign set_bits  = r_set_bits;
  assign sel_digit = r_sel;
  assign editing   = (r_mode == S_SET);

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control: directed scenarios with literal expectations plus
// randomized button traffic checked every cycle against a behavioural model.
module tb_timer_control;

  localparam int DB = 4;
  localparam logic [15:0] DMAX = 16'h5959;

  localparam logic [4:0] P_RST   = 5'b00001;
  localparam logic [4:0] P_SET   = 5'b00010;
  localparam logic [4:0] P_START = 5'b00100;
  localparam logic [4:0] P_INC   = 5'b01000;
  localparam logic [4:0] P_SEL   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  btn = 5'b0;
  logic [3:0]  state;
  logic [15:0] set_bits;
  logic [1:0]  sel_digit;
  logic        editing;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  timer_control #(.DEBOUNCE_CYCLES(DB), .DIGIT_MAX(DMAX)) dut (
    .clk       (clk),
    .reset     (rst),
    .btn_reset (btn[0]),
    .btn_set   (btn[1]),
    .btn_start (btn[2]),
    .btn_inc   (btn[3]),
    .btn_sel   (btn[4]),
    .state     (state),
    .set_bits  (set_bits),
    .sel_digit (sel_digit),
    .editing   (editing)
  );

  always #5 clk = ~clk;

  // Behavioural model: accepted button levels, press events, mode and preset digits.
  logic [4:0] m_s1, m_s2, m_acc, m_rose, m_pulse;
  int         m_run [5];
  int         m_mode;
  int         m_sel;
  int         m_dig [4];

  function automatic int dmax_of(input int d);
    logic [15:0] v;
    v = DMAX;
    return int'(v[d*4 +: 4]);
  endfunction

  function automatic int m_bits();
    return m_dig[0] + 16 * m_dig[1] + 256 * m_dig[2] + 4096 * m_dig[3];
  endfunction

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_acc = '0; m_rose = '0; m_pulse = '0;
    for (int b = 0; b < 5; b++) m_run[b] = 0;
    m_mode = 0; m_sel = 0;
    for (int d = 0; d < 4; d++) m_dig[d] = 0;
  endtask

  task automatic model_step();
    logic [4:0] act;
    act     = m_pulse;
    m_pulse = m_rose;
    m_rose  = '0;
    for (int b = 0; b < 5; b++) begin
      if (m_s2[b] != m_acc[b]) begin
        m_run[b] = m_run[b] + 1;
        if (m_run[b] == DB) begin
          m_acc[b] = ~m_acc[b];
          m_run[b] = 0;
          if (m_acc[b]) m_rose[b] = 1'b1;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn;
    if (act[0]) m_mode = 0;
    else if (act[2]) m_mode = 3;
    else if (act[1]) begin
      if (m_mode == 0) begin m_mode = 1; m_sel = 0; end
      else if (m_mode == 1) m_mode = 0;
    end else if (act[4]) begin
      if (m_mode == 1) m_sel = (m_sel + 1) % 4;
    end else if (act[3]) begin
      if (m_mode == 1) m_dig[m_sel] = (m_dig[m_sel] == dmax_of(m_sel)) ? 0 : m_dig[m_sel] + 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_clear();
    else model_step();
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_state", int'(state), m_mode);
      chk("m_set_bits", int'(set_bits), m_bits());
      chk("m_sel_digit", int'(sel_digit), m_sel);
      chk("m_editing", int'(editing), (m_mode == 1) ? 1 : 0);
    end
  end

  task automatic press(input logic [4:0] v);
    @(negedge clk);
    btn = v;
    repeat (8) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [4:0] v;
    int r;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_set_bits", int'(set_bits), 0);
    chk("rst_sel", int'(sel_digit), 0);
    chk("rst_editing", int'(editing), 0);
    rst = 1'b0;
    cmp_on = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_stable", int'(state), 0);

    // Glitch shorter than the debounce window.
    @(negedge clk);
    btn = P_START;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    chk("glitch_state", int'(state), 0);

    // Latency of a clean press.
    lat = 0;
    @(negedge clk);
    btn = P_START;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (state == 4'd3 && lat == 0) lat = n;
    end
    @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    chk("start_latency", lat, 8);
    chk("run_state", int'(state), 3);

    press(P_RST);
    chk("run_to_idle", int'(state), 0);

    // Set entry and editing.
    press(P_SET);
    chk("set_state", int'(state), 1);
    chk("set_editing", int'(editing), 1);
    repeat (7) press(P_INC);
    chk("inc7", int'(set_bits), 16'h0007);
    press(P_SEL);
    repeat (5) press(P_INC);
    chk("d1_at_max", int'(set_bits), 16'h0057);
    press(P_INC);
    chk("d1_wrap", int'(set_bits), 16'h0007);
    chk("sel_one", int'(sel_digit), 1);
    repeat (3) press(P_SEL);
    chk("sel_wrap", int'(sel_digit), 0);
    repeat (2) press(P_INC);
    chk("d0_nine", int'(set_bits), 16'h0009);
    press(P_INC);
    chk("d0_wrap", int'(set_bits), 16'h0000);
    repeat (4) press(P_SEL);
    chk("sel_x4", int'(sel_digit), 0);
    repeat (3) press(P_INC);
    chk("d0_three", int'(set_bits), 16'h0003);

    // RUN lock-out.
    press(P_START);
    chk("set_to_run", int'(state), 3);
    press(P_SET);
    press(P_INC);
    press(P_SEL);
    chk("run_lock_state", int'(state), 3);
    chk("run_lock_bits", int'(set_bits), 16'h0003);
    chk("run_lock_sel", int'(sel_digit), 0);
    press(P_RST);
    chk("run_rst_state", int'(state), 0);
    chk("run_rst_bits", int'(set_bits), 16'h0003);
    press(P_INC);
    chk("idle_inc_ignored", int'(set_bits), 16'h0003);

    // Priority: reset beats start in the same cycle.
    press(P_SET);
    chk("prio_pre", int'(state), 1);
    press(P_RST | P_START);
    chk("prio_rst_start", int'(state), 0);

    // Priority: start beats set, sel beats inc.
    press(P_SET);
    press(P_SEL | P_INC);
    chk("prio_sel_inc_sel", int'(sel_digit), 1);
    chk("prio_sel_inc_bits", int'(set_bits), 16'h0003);
    press(P_SET | P_START);
    chk("prio_start_set", int'(state), 3);
    press(P_RST);
    press(P_SET);
    press(P_SEL);

    // Asynchronous reset takes effect mid-cycle.
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_bits", int'(set_bits), 0);
    chk("async_sel", int'(sel_digit), 0);
    chk("async_editing", int'(editing), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a debounce discards the partial count.
    @(negedge clk);
    btn = P_START;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_debounce_rst", int'(state), 0);

    // Randomized traffic checked by the model.
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end else begin
        if (r < 12) v = 5'($urandom);
        else v = 5'b00001 << $urandom_range(0, 4);
        if (r >= 12 && v == P_RST && $urandom_range(0, 1) == 1) v = P_INC;
        @(negedge clk);
        btn = v;
        repeat ($urandom_range(1, 10)) @(negedge clk);
        btn = '0;
        repeat ($urandom_range(1, 10)) @(negedge clk);
      end
    end
    repeat (10) @(negedge clk);
    cmp_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_control.md
Name: timer_control

Overview:
- Upstream control stage for the countdown/stopwatch digit counters.
- Debounces the board push-buttons and runs the mode state machine that drives the shared 4-bit `state` bus (0 = reset, 1 = set, 3 = start) consumed by every digit counter.
- Holds the user-entered preset value for four digits and presents it on `set_bits` for the counters to load.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a button level is accepted (10 ms at 50 MHz).
- DIGIT_MAX, 16'h5959: packed per-digit maximum, digit0 in [3:0] through digit3 in [15:12]. Matches each counter's `maximumBits`.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- btn_reset  input  1  raw push-button, active-high, asynchronous to clk.
- btn_set  input  1  raw push-button: enter/leave set mode.
- btn_start  input  1  raw push-button: start counting.
- btn_inc  input  1  raw push-button: increment selected digit (set mode only).
- btn_sel  input  1  raw push-button: select next digit (set mode only).
- state  output  4  mode code to digit counters: 4'd0, 4'd1 or 4'd3 only.
- set_bits  output  16  preset value, 4 bits per digit, digit0 in [3:0].
- sel_digit  output  2  index of digit being edited.
- editing  output  1  high while in set mode (drives the display blink).

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high.
- Reset values: state=4'd0, set_bits=16'h0000, sel_digit=2'd0, editing=0. All synchroniser, debounce and pulse registers are cleared. Reset mid-debounce discards the partial count.
- Input conditioning, per button:
  - 2-flop synchroniser feeds a debounce counter.
  - While the synchronised level differs from the debounced level, the counter increments. Any cycle of agreement clears it to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A rising edge of the debounced level produces a press pulse lasting exactly 1 cycle. Releases produce no pulse.
  - Latency from a clean raw rise to its press pulse is 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.
- FSM states: IDLE (state=0), SET (state=1), RUN (state=3). `state` and `editing` are registered and update on the edge after the press pulse.
- Transitions:
  - IDLE: start -> RUN; set -> SET (sel_digit<=0).
  - SET: reset -> IDLE; start -> RUN; set -> IDLE.
  - RUN: reset -> IDLE. Set, start, inc and sel are ignored; the counters have no RUN->SET path.
- Simultaneous pulses: priority is reset > start > set > sel > inc. Only the highest-priority pulse acts in a given cycle.
- Digit editing, SET only:
  - inc: digit[sel_digit] <= (digit == DIGIT_MAX field) ? 0 : digit + 1.
  - sel: sel_digit <= sel_digit + 1, wrapping 3 -> 0.
  - Outside SET, inc and sel have no effect.
- set_bits is retained across IDLE/RUN; only the reset port clears it. A preset field larger than its max is impossible, since only inc writes it.
- editing = (FSM == SET).

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset then idle: assert reset mid-cycle -> state=0, set_bits=0000, sel_digit=0, editing=0 immediately (asynchronous). Outputs stable with buttons low.
- Debounce filter: btn_start high for 3 cycles then low -> no pulse, state stays 0. Held for 10 cycles -> state=3 exactly 2+4+1+1 = 8 edges after the rise, and only once.
- Set entry and edit: set press, then inc ×7, sel, inc ×6 -> state=1, editing=1, set_bits=16'h0007 then 16'h0007 and 16'h0000 in [7:4] wrapping (5 -> 0 on the 6th inc): final set_bits=16'h0007, sel_digit=1.
- Wrap of digit0: in SET with digit0=9 (DIGIT_MAX nibble 9), inc -> digit0=0. sel ×4 -> sel_digit returns to 0.
- RUN lock-out: from SET press start -> state=3. Then set, inc, sel presses -> state stays 3, set_bits unchanged. reset button -> state=0, set_bits retained.
- Priority and async reset: btn_reset and btn_start debounced in the same cycle while in SET -> state=0. Assert the reset port while a button is mid-debounce -> no pulse after release of reset.
